// File: rtl/ledger_pkg.sv
// ledger_pkg: shared definitions for the ledger memory datapath.
//   - word / address widths of the 11-bit ledger memory
//   - word tags ([10:8] of every ledger word)
//   - writeback FSM state enumeration
package ledger_pkg;

    localparam int unsigned WORD_W  = 11;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned TAG_W   = 3;
    localparam int unsigned VALUE_W = 8;

    localparam logic [TAG_W-1:0] TAG_BALANCE  = 3'b000;
    localparam logic [TAG_W-1:0] TAG_AMOUNT   = 3'b001;
    localparam logic [TAG_W-1:0] TAG_KEY      = 3'b010;
    localparam logic [TAG_W-1:0] TAG_COMPLETE = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        WR_P1,
        WR_P2,
        RD_P1,
        RD_P2,
        CMP_P2,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/balance_word_pack.sv
// balance_word_pack: forms a tagged balance word from a raw amount.
//   amount   in  11  raw balance from the transaction stage
//   word     out 11  {TAG_BALANCE, amount[7:0]}
//   overflow out 1   amount does not fit in the 8-bit value field
module balance_word_pack
    import ledger_pkg::*;
(
    input  logic [WORD_W-1:0] amount,
    output logic [WORD_W-1:0] word,
    output logic              overflow
);

    assign word     = {TAG_BALANCE, amount[VALUE_W-1:0]};
    assign overflow = |amount[WORD_W-1:VALUE_W];

endmodule

// File: rtl/ledger_writeback.sv
// ledger_writeback: writes both player balances to the ledger memory on a
// commit, reads them back, retries on mismatch and reports with a done pulse.
//   clock, reset           single clock, synchronous active-high reset
//   commit                 start request, sampled only when idle
//   p1/p2_amount_in        new balances, captured on accept
//   mem_data_out           ledger read data (1-cycle read latency)
//   mem_address/_data_in   ledger address / write data
//   mem_wren               ledger write enable
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse at the end of each accepted commit
//   error                  sticky failure flag, cleared on the next accept
module ledger_writeback
    import ledger_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P1_ADDR   = 5'd1,
    parameter logic [ADDR_W-1:0] P2_ADDR   = 5'd2,
    parameter int unsigned       MAX_RETRY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              commit,
    input  logic [WORD_W-1:0] p1_amount_in,
    input  logic [WORD_W-1:0] p2_amount_in,
    input  logic [WORD_W-1:0] mem_data_out,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data_in,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  p1_word_q, p2_word_q;
    logic [RETRY_W-1:0] retry_q;
    logic               p1_ok_q;
    logic               error_q;

    logic [WORD_W-1:0]  p1_word_in, p2_word_in;
    logic               p1_ovf, p2_ovf;
    logic               accept;
    logic               retry_inc;
    logic               wren_raw;

    balance_word_pack u_pack_p1 (
        .amount   (p1_amount_in),
        .word     (p1_word_in),
        .overflow (p1_ovf)
    );

    balance_word_pack u_pack_p2 (
        .amount   (p2_amount_in),
        .word     (p2_word_in),
        .overflow (p2_ovf)
    );

    assign accept = (state_q == IDLE) && commit;

    always_comb begin
        state_d     = state_q;
        mem_address = '0;
        mem_data_in = '0;
        wren_raw    = 1'b0;
        done        = 1'b0;
        retry_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = (p1_ovf || p2_ovf) ? FAIL : WR_P1;
                end
            end
            WR_P1: begin
                mem_address = P1_ADDR;
                mem_data_in = p1_word_q;
                wren_raw    = 1'b1;
                state_d     = WR_P2;
            end
            WR_P2: begin
                mem_address = P2_ADDR;
                mem_data_in = p2_word_q;
                wren_raw    = 1'b1;
                state_d     = RD_P1;
            end
            RD_P1: begin
                mem_address = P1_ADDR;
                state_d     = RD_P2;
            end
            RD_P2: begin
                mem_address = P2_ADDR;
                state_d     = CMP_P2;
            end
            CMP_P2: begin
                if (p1_ok_q && (mem_data_out == p2_word_q)) begin
                    state_d = DONE;
                end else if (32'(retry_q) < MAX_RETRY) begin
                    retry_inc = 1'b1;
                    state_d   = WR_P1;
                end else begin
                    state_d = FAIL;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            FAIL: begin
                done    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // A reset raised during a write cycle must keep that write off the memory.
    assign mem_wren = wren_raw & ~reset;
    assign busy     = (state_q != IDLE);
    assign error    = error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            p1_word_q <= '0;
            p2_word_q <= '0;
            retry_q   <= '0;
            p1_ok_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                p1_word_q <= p1_word_in;
                p2_word_q <= p2_word_in;
                retry_q   <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + RETRY_W'(1);
            end
            // P1 read data arrives while the P2 read is being issued.
            if (state_q == RD_P2) begin
                p1_ok_q <= (mem_data_out == p1_word_q);
            end
            // Set on entry so error is already high in the FAIL cycle.
            if (state_d == FAIL) begin
                error_q <= 1'b1;
            end else if (accept) begin
                error_q <= 1'b0;
            end
        end
    end

endmodule
